// File: rtl/iir_coe_loader_pkg.sv
// Shared constants and types for the IIR coefficient bank loader.
// The bank-0 reset set is a usable default filter that needs no host setup.
package iir_coe_loader_pkg;

   localparam int COE_W     = 17;
   localparam int NUM_BEATS = 6;
   localparam int HDR_BEATS = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   localparam int B0_DEF_B0 = 32768;
   localparam int B0_DEF_B1 = -58935;
   localparam int B0_DEF_B2 = 30050;
   localparam int B0_DEF_A0 = 32768;
   localparam int B0_DEF_A1 = -58935;
   localparam int B0_DEF_A2 = 30050;

   function automatic int bank0_default(input int k);
      case (k)
         0:       return B0_DEF_B0;
         1:       return B0_DEF_B1;
         2:       return B0_DEF_B2;
         3:       return B0_DEF_A0;
         4:       return B0_DEF_A1;
         default: return B0_DEF_A2;
      endcase
   endfunction

endpackage

// File: rtl/iir_coe_loader_bank.sv
// Coefficient register array: NUM_BANKS x 6 words, host write port with
// accept/reject check, and a combinational read port for the streamer.
module iir_coe_bank #(
   parameter int NUM_BANKS = 4,
   parameter int COE_W     = iir_coe_loader_pkg::COE_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
   input  logic [2:0]                   wr_idx,
   input  logic [COE_W-1:0]             wr_data,
   input  logic                         busy,
   input  logic [$clog2(NUM_BANKS)-1:0] stream_bank,
   output logic                         wr_err,
   input  logic [$clog2(NUM_BANKS)-1:0] rd_bank,
   input  logic [2:0]                   rd_idx,
   output logic [COE_W-1:0]             rd_data
);
   import iir_coe_loader_pkg::*;

   logic [COE_W-1:0] mem [NUM_BANKS][NUM_BEATS];
   logic             wr_ok;

   // The bank being streamed is frozen so the filter never sees a torn set.
   assign wr_ok = (wr_idx <= 3'(NUM_BEATS - 1)) &&
                  (32'(wr_bank) < NUM_BANKS) &&
                  !(busy && (wr_bank == stream_bank));

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_err <= 1'b0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_BEATS; k++) begin
               mem[b][k] <= (b == 0) ? COE_W'(bank0_default(k)) : '0;
            end
         end
      end else begin
         wr_err <= wr_en && !wr_ok;
         if (wr_en && wr_ok) begin
            mem[wr_bank][wr_idx] <= wr_data;
         end
      end
   end

   assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/iir_coe_loader.sv
// Streams a stored coefficient bank to the IIR filter as one header beat
// followed by six coefficients, then commits it; one request can queue.
module iir_coe_loader #(
   parameter int NUM_BANKS = 4,
   parameter int COE_W     = iir_coe_loader_pkg::COE_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
   input  logic [2:0]                   wr_idx,
   input  logic [COE_W-1:0]             wr_data,
   output logic                         wr_err,
   input  logic                         load_req,
   input  logic [$clog2(NUM_BANKS)-1:0] load_bank,
   output logic                         busy,
   output logic                         load_done,
   output logic [$clog2(NUM_BANKS)-1:0] active_bank,
   output logic [COE_W-1:0]             coe,
   output logic                         coe_en,
   output logic [1:0]                   dbg_state
);
   import iir_coe_loader_pkg::*;

   localparam int BW = $clog2(NUM_BANKS);

   state_t           state_q, state_d;
   logic [2:0]       beat_q, beat_d;
   logic [BW-1:0]    cur_bank_q, cur_bank_d;
   logic [BW-1:0]    pend_bank_q, pend_bank_d;
   logic             pend_q, pend_d;
   logic             load_ok;
   logic [COE_W-1:0] rd_data;

   assign load_ok   = load_req && (32'(load_bank) < NUM_BANKS);
   assign dbg_state = state_q;

   iir_coe_bank #(
      .NUM_BANKS (NUM_BANKS),
      .COE_W     (COE_W)
   ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_bank     (wr_bank),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .busy        (busy),
      .stream_bank (cur_bank_q),
      .wr_err      (wr_err),
      .rd_bank     (cur_bank_q),
      .rd_idx      (beat_q),
      .rd_data     (rd_data)
   );

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      cur_bank_d  = cur_bank_q;
      pend_d      = pend_q;
      pend_bank_d = pend_bank_q;
      case (state_q)
         ST_IDLE: begin
            // A fresh request overrides whatever was queued.
            if (load_ok) begin
               cur_bank_d = load_bank;
               pend_d     = 1'b0;
               beat_d     = '0;
               state_d    = ST_SYNC;
            end else if (pend_q) begin
               cur_bank_d = pend_bank_q;
               pend_d     = 1'b0;
               beat_d     = '0;
               state_d    = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (beat_q == 3'(HDR_BEATS - 1)) begin
               beat_d  = '0;
               state_d = ST_SHIFT;
            end else begin
               beat_d = beat_q + 3'd1;
            end
         end
         ST_SHIFT: begin
            if (beat_q == 3'(NUM_BEATS - 1)) begin
               beat_d  = '0;
               state_d = ST_COMMIT;
            end else begin
               beat_d = beat_q + 3'd1;
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if ((state_q != ST_IDLE) && load_ok) begin
         pend_d      = 1'b1;
         pend_bank_d = load_bank;
      end
   end

   // Filter-facing outputs are registered from the current state, so every
   // beat lands one cycle after the state that produced it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         cur_bank_q  <= '0;
         pend_q      <= 1'b0;
         pend_bank_q <= '0;
         busy        <= 1'b0;
         coe_en      <= 1'b0;
         coe         <= '0;
         load_done   <= 1'b0;
         active_bank <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         cur_bank_q  <= cur_bank_d;
         pend_q      <= pend_d;
         pend_bank_q <= pend_bank_d;
         busy        <= (state_q != ST_IDLE);
         coe_en      <= (state_q == ST_SYNC) || (state_q == ST_SHIFT);
         coe         <= (state_q == ST_SHIFT) ? rd_data : '0;
         load_done   <= (state_q == ST_COMMIT);
         if (state_q == ST_COMMIT) begin
            active_bank <= cur_bank_q;
         end
      end
   end

endmodule

// File: doc/iir_coe_loader.md
IIR_COE_LOADER -- requirements
Module: iir_coe_loader

Interface
REQ-001 Parameter NUM_BANKS, default 4: number of stored coefficient banks.
REQ-002 Parameter COE_W, default 17: signed coefficient width.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  host coefficient write strobe.
REQ-006 wr_bank  input  clog2(NUM_BANKS)  target bank of write.
REQ-007 wr_idx  input  3  coefficient index 0..5 (b0,b1,b2,a0,a1,a2).
REQ-008 wr_data  input  COE_W  signed coefficient value.
REQ-009 wr_err  output  1  one-cycle pulse, write rejected.
REQ-010 load_req  input  1  request to stream bank load_bank to filter.
REQ-011 load_bank  input  clog2(NUM_BANKS)  bank to load.
REQ-012 busy  output  1  high while a stream or commit is in progress.
REQ-013 load_done  output  1  one-cycle pulse, filter has committed new set.
REQ-014 active_bank  output  clog2(NUM_BANKS)  bank last committed.
REQ-015 coe  output  COE_W  coefficient beat to filter.
REQ-016 coe_en  output  1  coefficient beat valid to filter.

Function
REQ-017 Storage: NUM_BANKS x 6 register array of COE_W signed words.
REQ-018 Write accepted when wr_en=1, wr_idx<=5, and not (busy and wr_bank==streaming bank); stored next edge.
REQ-019 Rejected write (wr_idx>5, or target is streaming bank while busy) leaves storage unchanged and pulses wr_err the following cycle.
REQ-020 FSM states: IDLE, SYNC, SHIFT, COMMIT.
REQ-021 IDLE: on load_req (or pending request) latch bank, go SYNC; busy=1 from next cycle.
REQ-022 SYNC: one cycle, coe_en=1, coe=0 (header beat consumed by filter counter, not stored); go SHIFT.
REQ-023 SHIFT: six cycles, coe_en=1, coe = bank[k] for k=0..5 in order; beat counter 0..5; after k=5 go COMMIT.
REQ-024 COMMIT: one cycle, coe_en=0, load_done=1, active_bank<=latched bank; go IDLE, busy=0 next cycle.
REQ-025 Latency: load_req sampled at edge t -> coe_en high cycles t+1..t+7 (t+1 header, t+2..t+7 coefficients 0..5), load_done at t+8, busy low at t+9.
REQ-026 coe_en SHALL be exactly 7 consecutive cycles per load; never asserted outside SYNC/SHIFT; coe=0 when coe_en=0.
REQ-027 load_req while busy: stored in one-deep pending slot (bank captured); later requests while busy overwrite pending bank (latest wins); pending served from IDLE with no idle gap beyond one cycle.
REQ-028 load_req in IDLE same cycle as pending valid: new request wins, pending cleared.
REQ-029 load_bank >= NUM_BANKS: request ignored, no pulse.
REQ-030 Simultaneous accepted write and load_req of same bank in IDLE: write lands first, stream carries new value.

Reset
REQ-031 rst=1: FSM IDLE, pending cleared, busy=0, load_done=0, wr_err=0, coe_en=0, coe=0, active_bank=0.
REQ-032 rst=1: bank 0 = {32768, -58935, 30050, 32768, -58935, 30050}; all other banks 0.
REQ-033 rst mid-stream aborts immediately (coe_en=0 next edge, no load_done); block and filter SHALL share the same reset event so beat counting stays aligned.

Structure
REQ-034 Shared package holds COE_W, beat count (6), header-beat count (1), FSM state enum, and bank-0 default coefficient constants.
REQ-035 One sub-module iir_coe_bank (register array with write-accept/reject logic and read port); FSM and pending logic in top.

Verification
REQ-036 After reset, load_req bank0 -> coe_en 7 cycles, coe = 0,32768,-58935,30050,32768,-58935,30050; load_done at t+8; active_bank=0.
REQ-037 Write bank2 idx0..5 = 1..6, load bank2 -> beats 0,1,2,3,4,5,6; active_bank=2.
REQ-038 Write wr_idx=6 -> wr_err pulse, re-load shows bank unchanged.
REQ-039 While streaming bank1: write bank1 -> wr_err; write bank3 -> accepted; load_req bank2 then bank3 during busy -> next stream is bank3 only.
REQ-040 rst asserted at SHIFT beat 3 -> coe_en 0 next cycle, no load_done, bank0 restored to defaults.
